// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register unit with MULT/MADD/MSUB/MTHI/MTLO and iterative 32-step divider
module hilo_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  HiLoOp,
    input  logic [31:0] ProdHi,
    input  logic [31:0] ProdLo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Stall,
    output logic        DivByZero
);

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_MADD = 3'b010;
    localparam logic [2:0] OP_MSUB = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dbz;
    logic [31:0] r_dvd;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [31:0] r_dvs;
    logic [32:0] r_rem;
    logic        r_qneg;
    logic        r_rneg;
    logic [4:0]  r_cnt;

    logic        w_idle;
    logic        w_is_div;
    logic        w_signed;
    logic        w_issue_div;
    logic        w_issue_dbz;
    logic        w_last;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_raw;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_idle      = (r_state == S_IDLE);
    assign w_is_div    = HiLoOp[2] & HiLoOp[1];
    assign w_signed    = ~HiLoOp[0];
    assign w_issue_div = w_idle && w_is_div && (B != 32'd0);
    assign w_issue_dbz = w_idle && w_is_div && (B == 32'd0);
    assign w_last      = (r_cnt == 5'd31);

    assign w_a_abs = (w_signed && A[31]) ? (32'd0 - A) : A;
    assign w_b_abs = (w_signed && B[31]) ? (32'd0 - B) : B;

    // One restoring step: shift in the next dividend bit, keep the difference if it did not go negative
    assign w_shift    = {r_rem, r_dvd[31]};
    assign w_diff     = w_shift - {2'b00, r_dvs};
    assign w_ge       = ~w_diff[33];
    assign w_rem_next = w_ge ? w_diff[32:0] : w_shift[32:0];
    assign w_quo_raw  = {r_dvd[30:0], w_ge};

    // Sign correction: quotient truncates toward zero, remainder follows the dividend
    assign w_quo_fix = r_qneg ? (32'd0 - w_quo_raw) : w_quo_raw;
    assign w_rem_fix = r_rneg ? (32'd0 - w_rem_next[31:0]) : w_rem_next[31:0];

    assign Hi        = r_hi;
    assign Lo        = r_lo;
    assign Stall     = (r_state == S_RUN);
    assign DivByZero = r_dbz;

    // Divider FSM next-state: start on a non-zero divide, finish after the 32nd step
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue_div) w_next = S_RUN;
            S_RUN:   if (w_last)      w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Divider FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Divider datapath: latch operands on issue, iterate while running
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_dvd  <= 32'd0;
            r_dvs  <= 32'd0;
            r_rem  <= 33'd0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_cnt  <= 5'd0;
        end else if (w_issue_div) begin
            r_dvd  <= w_a_abs;
            r_dvs  <= w_b_abs;
            r_rem  <= 33'd0;
            r_qneg <= w_signed & (A[31] ^ B[31]);
            r_rneg <= w_signed & A[31];
            r_cnt  <= 5'd0;
        end else if (r_state == S_RUN) begin
            r_dvd <= w_quo_raw;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // HI/LO registers: ALU-fed ops when idle, divide results on the final step
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end else begin
            case (HiLoOp)
                OP_MULT: {r_hi, r_lo} <= {ProdHi, ProdLo};
                OP_MADD: {r_hi, r_lo} <= {r_hi, r_lo} + {ProdHi, ProdLo};
                OP_MSUB: {r_hi, r_lo} <= {r_hi, r_lo} - {ProdHi, ProdLo};
                OP_MTHI: r_hi <= A;
                OP_MTLO: r_lo <= A;
                default: ;
            endcase
        end
    end

    // Divide-by-zero flag: single-cycle pulse after a zero-divisor issue
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_dbz <= 1'b0;
        else       r_dbz <= w_issue_dbz;
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - randomized self-checking bench for hilo_unit
module tb_hilo_unit;

    localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MADD = 3'd2, MSUB = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, DIV = 3'd6, DIVU = 3'd7;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [2:0]  HiLoOp;
    logic [31:0] ProdHi, ProdLo, A, B;
    logic [31:0] Hi, Lo;
    logic        Stall, DivByZero;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    hilo_unit dut (
        .Clk(Clk), .Reset(Reset), .HiLoOp(HiLoOp), .ProdHi(ProdHi), .ProdLo(ProdLo),
        .A(A), .B(B), .Hi(Hi), .Lo(Lo), .Stall(Stall), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic do_op(input logic [2:0] op, input logic [31:0] ph, input logic [31:0] pl,
                         input logic [31:0] a, input logic [31:0] b);
        HiLoOp = op; ProdHi = ph; ProdLo = pl; A = a; B = b;
        @(posedge Clk); #1;
        HiLoOp = NONE;
    endtask

    task automatic model_op(input logic [2:0] op, input logic [31:0] ph, input logic [31:0] pl,
                            input logic [31:0] a);
        logic [63:0] acc;
        acc = {m_hi, m_lo};
        case (op)
            MULT: acc = {ph, pl};
            MADD: acc = acc + {ph, pl};
            MSUB: acc = acc - {ph, pl};
            MTHI: acc[63:32] = a;
            MTLO: acc[31:0] = a;
            default: ;
        endcase
        {m_hi, m_lo} = acc;
    endtask

    task automatic ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (op == DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0];
            r = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; HiLoOp = NONE; ProdHi = 0; ProdLo = 0; A = 0; B = 0;
        #2;
        checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", Hi); end
        checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", Lo); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", DivByZero); end
        @(negedge Clk); Reset = 1'b0;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_accumulate;
        do_op(MULT, 32'd0, 32'd1, 32'd0, 32'd0); model_op(MULT, 32'd0, 32'd1, 32'd0);
        checks++; if ({Hi, Lo} !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL acc_mult got=%h_%h exp=0_1", Hi, Lo); end
        do_op(MADD, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0); model_op(MADD, 32'd0, 32'hFFFF_FFFF, 32'd0);
        checks++; if ({Hi, Lo} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL acc_madd got=%h_%h exp=1_0", Hi, Lo); end
        do_op(MSUB, 32'd0, 32'd1, 32'd0, 32'd0); model_op(MSUB, 32'd0, 32'd1, 32'd0);
        checks++; if ({Hi, Lo} !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL acc_msub got=%h_%h exp=0_ffffffff", Hi, Lo); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  op;
        logic [31:0] ph, pl, a;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 5));
            ph = $urandom; pl = $urandom; a = $urandom;
            do_op(op, ph, pl, a, $urandom);
            model_op(op, ph, pl, a);
            checks++;
            if ({Hi, Lo} !== {m_hi, m_lo} || Stall !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d got=%h_%h stall=%b exp=%h_%h", i, op, Hi, Lo, Stall, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_divide(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        int          cycles;
        logic        held;
        if (b == 32'd0) begin
            do_op(op, 32'd0, 32'd0, a, b);
            checks++;
            if (DivByZero !== 1'b1 || Stall !== 1'b0 || {Hi, Lo} !== {m_hi, m_lo}) begin
                errors++;
                $display("FAIL dbz_issue dbz=%b stall=%b got=%h_%h exp=1 0 %h_%h", DivByZero, Stall, Hi, Lo, m_hi, m_lo);
            end
            @(posedge Clk); #1;
            checks++;
            if (DivByZero !== 1'b0 || Stall !== 1'b0 || {Hi, Lo} !== {m_hi, m_lo}) begin
                errors++;
                $display("FAIL dbz_after dbz=%b stall=%b got=%h_%h exp=0 0 %h_%h", DivByZero, Stall, Hi, Lo, m_hi, m_lo);
            end
            return;
        end
        ref_div(op, a, b, q, r);
        do_op(op, 32'd0, 32'd0, a, b);
        cycles = 0;
        held = 1'b1;
        while (Stall === 1'b1 && cycles < 100) begin
            if ({Hi, Lo} !== {m_hi, m_lo}) held = 1'b0;
            @(posedge Clk); #1;
            cycles++;
        end
        checks++;
        if (cycles != 32) begin errors++; $display("FAIL div_stall_len a=%h b=%h got=%0d exp=32", a, b, cycles); end
        checks++;
        if (!held) begin errors++; $display("FAIL div_hold a=%h b=%h got=changed exp=%h_%h", a, b, m_hi, m_lo); end
        m_hi = r; m_lo = q;
        checks++;
        if (Hi !== r || Lo !== q || DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL div_result op=%0d a=%h b=%h got=%h_%h dbz=%b exp=%h_%h", op, a, b, Hi, Lo, DivByZero, r, q);
        end
    endtask

    task automatic test_divide_directed;
        test_divide(DIV, 32'hFFFF_FFF9, 32'd2);
        checks++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got=%h_%h exp=ffffffff_fffffffd", Hi, Lo); end
        test_divide(DIVU, 32'd7, 32'd2);
        checks++; if ({Hi, Lo} !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL divu_7_2 got=%h_%h exp=1_3", Hi, Lo); end
        test_divide(DIVU, 32'hFFFF_FFFF, 32'h10);
        checks++; if ({Hi, Lo} !== 64'h0000_000F_0FFF_FFFF) begin errors++; $display("FAIL divu_big got=%h_%h exp=f_0fffffff", Hi, Lo); end
    endtask

    task automatic test_overflow_dbz;
        test_divide(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++; if ({Hi, Lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got=%h_%h exp=0_80000000", Hi, Lo); end
        test_divide(DIV, 32'd5, 32'd0);
        test_divide(DIVU, 32'hDEAD_BEEF, 32'd0);
    endtask

    task automatic test_random_div;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            if (i == 3) a = 32'h8000_0000;
            test_divide(op, a, b);
        end
    endtask

    task automatic test_stall_ignore;
        int cycles;
        do_op(DIVU, 32'd0, 32'd0, 32'd100, 32'd7);
        HiLoOp = MTHI; A = 32'h1234;
        cycles = 0;
        while (Stall === 1'b1 && cycles < 100) begin
            @(posedge Clk); #1;
            cycles++;
        end
        checks++;
        if (cycles != 32 || Hi !== 32'd2 || Lo !== 32'd14) begin
            errors++;
            $display("FAIL stall_ignore cycles=%0d got=%h_%h exp=32 2_e", cycles, Hi, Lo);
        end
        @(posedge Clk); #1;
        HiLoOp = NONE;
        m_hi = 32'h1234; m_lo = 32'd14;
        checks++;
        if (Hi !== 32'h1234 || Lo !== 32'd14) begin
            errors++;
            $display("FAIL mthi_after_stall got=%h_%h exp=1234_e", Hi, Lo);
        end
    endtask

    task automatic test_reset_mid_divide;
        logic [31:0] ph, pl;
        do_op(DIVU, 32'd0, 32'd0, 32'hFFFF_0000, 32'd3);
        repeat (9) @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if (Hi !== 32'd0 || Lo !== 32'd0 || Stall !== 1'b0 || DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got=%h_%h stall=%b dbz=%b exp=0_0 0 0", Hi, Lo, Stall, DivByZero);
        end
        @(negedge Clk); Reset = 1'b0;
        m_hi = 0; m_lo = 0;
        ph = $urandom; pl = $urandom;
        do_op(MULT, ph, pl, 32'd0, 32'd0);
        model_op(MULT, ph, pl, 32'd0);
        checks++;
        if ({Hi, Lo} !== {m_hi, m_lo} || Stall !== 1'b0) begin
            errors++;
            $display("FAIL mult_after_reset got=%h_%h stall=%b exp=%h_%h", Hi, Lo, Stall, m_hi, m_lo);
        end
    endtask

    initial begin
        test_reset;
        test_accumulate;
        test_back_to_back;
        test_divide_directed;
        test_overflow_dbz;
        test_random_div;
        test_back_to_back;
        test_stall_ignore;
        test_reset_mid_divide;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
